// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps the shared ALU, unified memory and
// register file through fetch/decode/execute/memory/writeback, waiting on
// the memory ready handshake and flagging unknown opcodes.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                PCEn,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                SignZero,
  output logic [1:0]          PCSource,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_op,
  output logic                instr_done
);

  localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTE   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALU_WB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_IMM_EXEC  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_IMM_WB    = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(11);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_pc_write;
  logic               w_branch;
  logic               w_ir_write;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode from the current state (Mealy on mem_ready).
  always_comb begin
    w_next     = S_FETCH;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    w_ir_write = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    SignZero   = 1'b0;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_XORI:      w_next = S_IMM_EXEC;
          OP_BNE:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = 2'b11;
        SignZero = 1'b1;
        w_next   = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite   = 1'b1;
        SignZero   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        w_branch   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        w_pc_write = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // PC and IR loads are suppressed while reset is held, even though FETCH decode is active.
  assign PCEn    = reset_n & (w_pc_write | (w_branch & ~Zero));
  assign IRWrite = reset_n & w_ir_write;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed reset/abort checks, then a
// scoreboard of per-cycle expected controls and per-instruction latency.
module tb_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       SignZero;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  multicycle_control #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .SignZero(SignZero), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, mrd, mwr, irw, regdst, m2r, rw, srca;
    logic [1:0] srcb, aluop;
    logic       sz;
    logic [1:0] pcsrc;
    logic       ill, done;
  } cyc_t;

  typedef struct {
    logic mr;
    logic z;
    cyc_t exp;
  } stim_t;

  int n_cmp = 0;
  int n_err = 0;

  cyc_t        sb_q[$];
  int unsigned lat_q[$];
  stim_t       plan[$];
  logic        sb_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input cyc_t e, input logic mr, input logic z);
    stim_t s;
    s.mr = mr;
    s.z = z;
    s.exp = e;
    plan.push_back(s);
  endtask

  // Instruction length straight from the published latency figures plus stalls.
  function automatic int unsigned latency(input logic [5:0] op, input int unsigned fs,
                                          input int unsigned ms);
    case (op)
      6'b100011: return 5 + fs + ms;
      6'b101011: return 4 + fs + ms;
      6'b000000, 6'b001110: return 4 + fs;
      6'b000101, 6'b000010: return 3 + fs;
      default: return 2 + fs;
    endcase
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, with its input drive.
  // zmode: 0/1 forces Zero in the branch cycle, 2 randomises it.
  task automatic build(input logic [5:0] op, input int unsigned fs, input int unsigned ms,
                       input int zmode);
    cyc_t c;
    logic z;
    plan.delete();
    for (int unsigned i = 0; i < fs; i++) begin
      c = blank(4'd0); c.mrd = 1'b1; c.srcb = 2'b01;
      add(c, 1'b0, rb());
    end
    c = blank(4'd0); c.mrd = 1'b1; c.srcb = 2'b01; c.irw = 1'b1; c.pcen = 1'b1;
    add(c, 1'b1, rb());
    c = blank(4'd1); c.srcb = 2'b11;
    case (op)
      6'b000000: begin
        add(c, rb(), rb());
        c = blank(4'd6); c.srca = 1'b1; c.aluop = 2'b10; add(c, rb(), rb());
        c = blank(4'd7); c.regdst = 1'b1; c.rw = 1'b1; c.done = 1'b1; add(c, rb(), rb());
      end
      6'b100011, 6'b101011: begin
        add(c, rb(), rb());
        c = blank(4'd2); c.srca = 1'b1; c.srcb = 2'b10; add(c, rb(), rb());
        if (op == 6'b100011) begin
          c = blank(4'd3); c.mrd = 1'b1; c.iord = 1'b1;
          for (int unsigned i = 0; i < ms; i++) add(c, 1'b0, rb());
          add(c, 1'b1, rb());
          c = blank(4'd4); c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1; add(c, rb(), rb());
        end else begin
          c = blank(4'd5); c.mwr = 1'b1; c.iord = 1'b1;
          for (int unsigned i = 0; i < ms; i++) add(c, 1'b0, rb());
          c.done = 1'b1; add(c, 1'b1, rb());
        end
      end
      6'b001110: begin
        add(c, rb(), rb());
        c = blank(4'd8); c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b11; c.sz = 1'b1;
        add(c, rb(), rb());
        c = blank(4'd9); c.rw = 1'b1; c.sz = 1'b1; c.done = 1'b1; add(c, rb(), rb());
      end
      6'b000101: begin
        add(c, rb(), rb());
        z = (zmode == 2) ? rb() : (zmode == 1);
        c = blank(4'd10); c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.pcen = ~z; c.done = 1'b1; add(c, rb(), z);
      end
      6'b000010: begin
        add(c, rb(), rb());
        c = blank(4'd11); c.pcsrc = 2'b10; c.pcen = 1'b1; c.done = 1'b1; add(c, rb(), rb());
      end
      default: begin
        c.ill = 1'b1; c.done = 1'b1; add(c, rb(), rb());
      end
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input int unsigned fs, input int unsigned ms,
                           input int zmode);
    build(op, fs, ms, zmode);
    lat_q.push_back(latency(op, fs, ms));
    Opcode = op;
    foreach (plan[k]) begin
      mem_ready = plan[k].mr;
      Zero = plan[k].z;
      sb_q.push_back(plan[k].exp);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expected cycle per sample; instruction length checked at instr_done.
  initial begin
    cyc_t exp, act;
    int unsigned cyc_cnt;
    cyc_cnt = 0;
    forever begin
      @(negedge clk);
      if (sb_run && sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        act.st = state; act.pcen = PCEn; act.iord = IorD; act.mrd = MemRead;
        act.mwr = MemWrite; act.irw = IRWrite; act.regdst = RegDst; act.m2r = MemtoReg;
        act.rw = RegWrite; act.srca = ALUSrcA; act.srcb = ALUSrcB; act.aluop = ALUOp;
        act.sz = SignZero; act.pcsrc = PCSource; act.ill = illegal_op; act.done = instr_done;
        check("cycle", 32'(act), 32'(exp));
        check("mem_rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        check("regwr_pcen_excl", {31'd0, RegWrite & PCEn}, 32'd0);
        cyc_cnt++;
        if (instr_done) begin
          if (lat_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL latency: unexpected instr_done, no instruction pending at %0t", $time);
          end else begin
            check("latency", cyc_cnt, lat_q.pop_front());
          end
          cyc_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int unsigned r;
    reset_n = 1'b0; mem_ready = 1'b1; Opcode = 6'b000000; Zero = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pcen", 32'(PCEn), 32'd0);
    check("rst_irwrite", 32'(IRWrite), 32'd0);
    check("rst_memread", 32'(MemRead), 32'd1);
    reset_n = 1'b1;
    #1;
    check("first_irwrite", 32'(IRWrite), 32'd1);
    check("first_pcen", 32'(PCEn), 32'd1);

    // sw abort: reach MEM_WRITE, stall, then reset mid-cycle.
    Opcode = 6'b101011;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #2;
    check("abort_state_memwrite", 32'(state), 32'd5);
    check("abort_memwrite_on", 32'(MemWrite), 32'd1);
    #1 reset_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("abort_memwrite_off", 32'(MemWrite), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_pcen", 32'(PCEn), 32'd0);
    check("abort_irwrite", 32'(IRWrite), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 32'(instr_done), 32'd0);
    end
    #1 reset_n = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("post_abort_state", 32'(state), 32'd0);
    check("post_abort_no_done", 32'(instr_done), 32'd0);

    sb_run = 1'b1;
    run_instr(6'b000000, 0, 0, 2);
    run_instr(6'b100011, 0, 2, 2);
    run_instr(6'b000101, 0, 0, 0);
    run_instr(6'b000101, 0, 0, 1);
    run_instr(6'b001110, 0, 0, 2);
    run_instr(6'b000010, 0, 0, 2);
    run_instr(6'b111111, 0, 0, 2);
    run_instr(6'b101011, 1, 0, 2);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b001110;
        4: op = 6'b000101;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                 op == 6'b001110 || op == 6'b000101 || op == 6'b000010)
            op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end
    @(negedge clk);
    #1;
    check("sb_queue_drained", 32'(sb_q.size()), 32'd0);
    check("lat_queue_drained", 32'(lat_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath.
- Replaces single-cycle decode with a Moore/Mealy FSM that steps the shared ALU, single unified memory and register file through fetch, decode, execute, memory and writeback.
- Supports R-type, lw, sw, bne, xori and j, using the existing opcode encodings.
- Waits on a memory ready handshake and flags illegal opcodes.

Parameters:
- OPCODE_W, 6, opcode field width.
- STATE_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Opcode  input  6  instruction bits [31:26], taken from the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCEn  output  1  PC write enable: PCWrite | (Branch & ~Zero).
- IorD  output  1  memory address mux: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  write register select: 1 = rd, 0 = rt.
- MemtoReg  output  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU operand A: 0 = PC, 1 = rs.
- ALUSrcB  output  2  ALU operand B: 00 = rt, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- ALUOp  output  2  00 add, 01 sub, 10 funct, 11 xor.
- SignZero  output  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- PCSource  output  2  next PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  output  4  current state, for debug.
- illegal_op  output  1  one-cycle pulse on an unknown opcode.
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - EXECUTE=6, ALU_WB=7, IMM_EXEC=8, IMM_WB=9, BRANCH=10, JUMP=11
  - 12-15 unused; any unused state returns to FETCH on the next edge.
- Reset: while reset_n=0, state=FETCH asynchronously. All outputs are decoded from state, so FETCH values apply, but PCEn and IRWrite are forced to 0 during reset. Reset mid-instruction abandons it; no partial writeback.
- Outputs are combinational from state plus mem_ready and Zero. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCEn=mem_ready.
  - Stays in FETCH until mem_ready=1, then moves to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by Opcode: 000000 -> EXECUTE; 100011 or 101011 -> MEM_ADDR; 001110 -> IMM_EXEC; 000101 -> BRANCH; 000010 -> JUMP.
  - Any other opcode: illegal_op=1 and instr_done=1 this cycle, then FETCH.
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00, SignZero=0.
  - Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1, then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then ALU_WB.
- ALU_WB: RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1, then FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, SignZero=1, then IMM_WB.
- IMM_WB: RegDst=0, RegWrite=1, MemtoReg=0, SignZero=1, instr_done=1, then FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, Branch=1, so PCEn=~Zero.
  - instr_done=1, then FETCH.
- JUMP: PCSource=10, PCWrite=1 (PCEn=1), instr_done=1, then FETCH.
- Latency with zero-wait memory (mem_ready held high):
  - lw = 5 cycles
  - R-type, xori, sw = 4 cycles
  - bne, j = 3 cycles
  - illegal = 2 cycles
- Each wait cycle on mem_ready adds 1 cycle in FETCH, MEM_READ or MEM_WRITE.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- MemRead and MemWrite are never both 1.
- RegWrite and PCEn are never 1 in the same cycle.

Test Plan:
- Reset: reset_n=0 asserted asynchronously mid-clock -> state=0, PCEn=0, IRWrite=0. After release with mem_ready=1, IRWrite=1 in the first cycle.
- R-type: Opcode=000000, mem_ready=1 -> states 0,1,6,7. RegWrite=1 with RegDst=1 in cycle 4, instr_done pulses once, and state returns to 0.
- lw with memory stall: Opcode=100011, mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4. MEM_WB drives MemtoReg=1 and RegWrite=1; total 7 cycles.
- bne: Opcode=000101, Zero=0 -> PCEn=1 with PCSource=01 in BRANCH. With Zero=1 -> PCEn=0. Both cases return to FETCH after 3 cycles.
- xori and j:
  - xori: IMM_EXEC shows ALUOp=11, SignZero=1, ALUSrcB=10.
  - j: JUMP shows PCSource=10, PCEn=1, RegWrite=0.
- Illegal opcode and abort:
  - Opcode=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH.
  - Reset asserted in MEM_WRITE -> MemWrite drops to 0 immediately and no instr_done pulse follows.
